// File: rtl/spi_adc_array_rx.sv
// Shared-SCLK SPI receiver: one CS/SCLK pair drives NUM_CH ADCs and all MISO lines
// are captured on the same SCLK rising edge, then handed off over valid/ready.
module spi_adc_array_rx #(
  parameter int WIDTH      = 10,
  parameter int TOTAL_BITS = 14,
  parameter int LEAD_BITS  = 2,
  parameter int NUM_CH     = 4,
  parameter int CLK_DIV    = 4,
  parameter int CS_IDLE    = 2
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    SPI_en,
  input  logic                    continuous,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       SPI_Data_in,
  output logic                    SPI_clk,
  output logic                    CS,
  output logic [NUM_CH*WIDTH-1:0] SPI_Data_out,
  output logic                    Data_Valid,
  input  logic                    Data_Ready,
  output logic                    Overrun,
  output logic                    Busy
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_MAX = (2 * TOTAL_BITS > CS_IDLE) ? 2 * TOTAL_BITS : CS_IDLE;
  localparam int HALF_W   = $clog2(HALF_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] SHIFT_LAST = HALF_W'(2 * TOTAL_BITS - 1);
  localparam logic [HALF_W-1:0] GAP_LAST   = HALF_W'(CS_IDLE - 1);
  localparam logic [HALF_W-1:0] KEEP_FIRST = HALF_W'(2 * LEAD_BITS);
  localparam logic [HALF_W-1:0] KEEP_END   = HALF_W'(2 * (LEAD_BITS + WIDTH));

  typedef enum logic [1:0] {IDLE, ASSERT, SHIFT, GAP} state_t;

  state_t                         stateQ;
  logic [DIV_W-1:0]               divQ, divD;
  logic [HALF_W-1:0]              halfQ;
  logic                           sclkQ, csQ, captureDoneQ;
  logic [NUM_CH-1:0][WIDTH-1:0]   shiftQ, dataQ;
  logic                           validQ, overrunQ;
  logic                           tick, keepBit;

  // Half-period timebase; halfQ is even whenever SCLK is about to rise, so 2k marks edge k.
  always_comb begin
    tick    = (stateQ != IDLE) && (divQ == DIV_LAST);
    divD    = divQ + 1'b1;
    if (stateQ == IDLE || tick) divD = '0;
    keepBit = (halfQ >= KEEP_FIRST) && (halfQ < KEEP_END);
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      stateQ       <= IDLE;
      divQ         <= '0;
      halfQ        <= '0;
      sclkQ        <= 1'b1;
      csQ          <= 1'b1;
      captureDoneQ <= 1'b0;
      shiftQ       <= '0;
    end else begin
      divQ         <= divD;
      captureDoneQ <= 1'b0;
      case (stateQ)
        IDLE: begin
          halfQ <= '0;
          if (SPI_en && (continuous || start)) begin
            stateQ <= ASSERT;
            csQ    <= 1'b0;
          end
        end
        ASSERT: begin
          if (tick) begin
            stateQ <= SHIFT;
            sclkQ  <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclkQ && keepBit) begin
              for (int ch = 0; ch < NUM_CH; ch++)
                shiftQ[ch] <= {shiftQ[ch][WIDTH-2:0], SPI_Data_in[ch]};
            end
            // The last half-period is high, so SCLK is left high on the way into GAP.
            if (halfQ == SHIFT_LAST) begin
              stateQ       <= GAP;
              csQ          <= 1'b1;
              halfQ        <= '0;
              captureDoneQ <= 1'b1;
            end else begin
              halfQ <= halfQ + 1'b1;
              sclkQ <= ~sclkQ;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (halfQ == GAP_LAST) begin
              halfQ <= '0;
              if (SPI_en && continuous) begin
                stateQ <= ASSERT;
                csQ    <= 1'b0;
              end else begin
                stateQ <= IDLE;
              end
            end else begin
              halfQ <= halfQ + 1'b1;
            end
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  // A finished capture is only loaded if the output slot is free or being drained this cycle.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      dataQ    <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else if (captureDoneQ && (!validQ || Data_Ready)) begin
      dataQ  <= shiftQ;
      validQ <= 1'b1;
    end else begin
      if (captureDoneQ)          overrunQ <= 1'b1;
      if (validQ && Data_Ready)  validQ   <= 1'b0;
    end
  end

  assign SPI_clk      = sclkQ;
  assign CS           = csQ;
  assign SPI_Data_out = dataQ;
  assign Data_Valid   = validQ;
  assign Overrun      = overrunQ;
  assign Busy         = (stateQ != IDLE);

endmodule

// File: tb/tb_spi_adc_array_rx.sv
// Bench for spi_adc_array_rx: behavioural ADC models feed random frames, a monitor logs
// handshakes and SPI edges, and directed steps compare against frame arithmetic.
module tb_spi_adc_array_rx;

  localparam int W = 10, T = 14, L = 2, N = 4, D = 4, CI = 2;
  localparam int PERIOD = D * (1 + 2 * T + CI);
  localparam int W2 = 12, T2 = 16, L2 = 4, N2 = 2, D2 = 1;
  localparam int PERIOD2 = D2 * (1 + 2 * T2 + CI);

  logic clk = 1'b0;
  logic reset_b, SPI_en, continuous, start, Data_Ready;
  logic [N-1:0] SPI_Data_in = '0;
  logic SPI_clk, CS, Data_Valid, Overrun, Busy;
  logic [N*W-1:0] SPI_Data_out;

  logic en2, cont2, start2, ready2;
  logic [N2-1:0] miso2 = '0;
  logic sclk2, cs2, valid2, overrun2, busy2;
  logic [N2*W2-1:0] data2;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_adc_array_rx #(.WIDTH(W), .TOTAL_BITS(T), .LEAD_BITS(L), .NUM_CH(N), .CLK_DIV(D), .CS_IDLE(CI)) dut (
    .clk(clk), .reset_b(reset_b), .SPI_en(SPI_en), .continuous(continuous), .start(start),
    .SPI_Data_in(SPI_Data_in), .SPI_clk(SPI_clk), .CS(CS), .SPI_Data_out(SPI_Data_out),
    .Data_Valid(Data_Valid), .Data_Ready(Data_Ready), .Overrun(Overrun), .Busy(Busy));

  spi_adc_array_rx #(.WIDTH(W2), .TOTAL_BITS(T2), .LEAD_BITS(L2), .NUM_CH(N2), .CLK_DIV(D2), .CS_IDLE(CI)) dut2 (
    .clk(clk), .reset_b(reset_b), .SPI_en(en2), .continuous(cont2), .start(start2),
    .SPI_Data_in(miso2), .SPI_clk(sclk2), .CS(cs2), .SPI_Data_out(data2),
    .Data_Valid(valid2), .Data_Ready(ready2), .Overrun(overrun2), .Busy(busy2));

  // ADC models: each frame word is chosen when CS falls and shifted out MSB first on SCLK falls.
  logic useFixed = 1'b0;
  logic [W-1:0] fixedData [N] = '{10'h2A5, 10'h000, 10'h3FF, 10'h155};
  logic [T-1:0] curWord [N];
  logic [T2-1:0] curWord2 [N2];
  int fallCnt = 0, fallCnt2 = 0;
  logic [N*W-1:0] frameExp [$];
  logic [N2*W2-1:0] exp2Q [$];

  function automatic logic [T-1:0] pickWord(input int ch);
    logic [1:0] tail;
    tail = 2'($urandom);
    if (useFixed) return {2'b00, fixedData[ch], tail};
    return T'($urandom);
  endfunction

  function automatic logic [N*W-1:0] expectedFrame();
    logic [N*W-1:0] e;
    for (int ch = 0; ch < N; ch++) e[ch*W +: W] = W'(curWord[ch] >> (T - L - W));
    return e;
  endfunction

  function automatic logic [N2*W2-1:0] expectedFrame2();
    logic [N2*W2-1:0] e;
    for (int ch = 0; ch < N2; ch++) e[ch*W2 +: W2] = W2'(curWord2[ch] >> (T2 - L2 - W2));
    return e;
  endfunction

  always @(negedge CS) begin
    fallCnt <= 0;
    for (int ch = 0; ch < N; ch++) curWord[ch] <= pickWord(ch);
  end

  always @(negedge SPI_clk) begin
    if (!CS && fallCnt < T) begin
      if (fallCnt == 0) frameExp.push_back(expectedFrame());
      for (int ch = 0; ch < N; ch++) SPI_Data_in[ch] <= curWord[ch][T-1-fallCnt];
      fallCnt <= fallCnt + 1;
    end
  end

  always @(negedge cs2) begin
    fallCnt2 <= 0;
    for (int ch = 0; ch < N2; ch++) curWord2[ch] <= T2'($urandom);
  end

  always @(negedge sclk2) begin
    if (!cs2 && fallCnt2 < T2) begin
      if (fallCnt2 == 0) exp2Q.push_back(expectedFrame2());
      for (int ch = 0; ch < N2; ch++) miso2[ch] <= curWord2[ch][T2-1-fallCnt2];
      fallCnt2 <= fallCnt2 + 1;
    end
  end

  // Monitors sample on the falling clk edge, away from every DUT update.
  logic prevSclk = 1'b1, prevCs = 1'b1, prevBusy = 1'b0;
  int sclkRise = 0, validHigh = 0, busyFallCyc = 0, csFalls = 0;
  int csFallQ [$], csRiseQ [$], accCycQ [$], acc2CycQ [$];
  logic [N*W-1:0] accQ [$];
  logic [N2*W2-1:0] acc2Q [$];

  always @(negedge clk) begin
    if (!prevSclk && SPI_clk && !CS) sclkRise <= sclkRise + 1;
    if (prevCs && !CS) begin
      csFallQ.push_back(cyc);
      csFalls <= csFalls + 1;
    end
    if (!prevCs && CS) csRiseQ.push_back(cyc);
    if (Data_Valid) validHigh <= validHigh + 1;
    if (Data_Valid && Data_Ready) begin
      accQ.push_back(SPI_Data_out);
      accCycQ.push_back(cyc);
    end
    if (prevBusy && !Busy) busyFallCyc <= cyc;
    if (valid2 && ready2) begin
      acc2Q.push_back(data2);
      acc2CycQ.push_back(cyc);
    end
    prevSclk <= SPI_clk;
    prevCs   <= CS;
    prevBusy <= Busy;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Inputs change just after a rising edge so neither the DUT nor the monitor races them.
  task automatic applyStimulus(input logic en, input logic cont, input logic st, input logic ready);
    @(posedge clk);
    #2;
    SPI_en = en;
    continuous = cont;
    start = st;
    Data_Ready = ready;
    if (st) begin
      @(posedge clk);
      #2;
      start = 1'b0;
    end
  endtask

  int a0, fe0, cf0, cr0, c0, s0, v0, cycV, cycO;
  logic [N*W-1:0] held;

  initial begin
    reset_b = 1'b1; SPI_en = 1'b0; continuous = 1'b0; start = 1'b0; Data_Ready = 1'b1;
    en2 = 1'b0; cont2 = 1'b0; start2 = 1'b0; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_sclk", SPI_clk, 1);
    checkOutput("rst_cs", CS, 1);
    checkOutput("rst_data", SPI_Data_out, 0);
    checkOutput("rst_valid", Data_Valid, 0);
    checkOutput("rst_overrun", Overrun, 0);
    checkOutput("rst_busy", Busy, 0);
    reset_b = 1'b0;
    repeat (2) @(negedge clk);

    // Single-shot frame with the fixed pattern.
    useFixed = 1'b1;
    a0 = accQ.size(); f0_set();
    s0 = sclkRise; v0 = validHigh;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !Busy; i++) @(negedge clk);
    for (int i = 0; i < PERIOD + 20 && Busy; i++) @(negedge clk);
    checkOutput("ss_done", Busy, 0);
    repeat (4) @(negedge clk);
    checkOutput("ss_count", accQ.size() - a0, 1);
    checkOutput("ss_data", (accQ.size() > a0) ? accQ[a0] : 'x, {10'h155, 10'h3FF, 10'h000, 10'h2A5});
    checkOutput("ss_valid_width", validHigh - v0, 1);
    checkOutput("ss_sclk_rises", sclkRise - s0, T);
    checkOutput("ss_busy_time", busyFallCyc - csFallQ[cf0], PERIOD);
    checkOutput("ss_overrun", Overrun, 0);
    useFixed = 1'b0;

    // Continuous frames with random ADC data.
    a0 = accQ.size(); fe0 = frameExp.size(); cf0 = csFallQ.size(); cr0 = csRiseQ.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6 * PERIOD && accQ.size() < a0 + 5; i++) @(negedge clk);
    SPI_en = 1'b0;
    for (int i = 0; i < 2 * PERIOD && Busy; i++) @(negedge clk);
    checkOutput("cont_idle", Busy, 0);
    checkOutput("cont_count", accQ.size() - a0, 5);
    for (int k = 1; k < 5; k++) checkOutput("cont_spacing", accCycQ[a0+k] - accCycQ[a0+k-1], PERIOD);
    for (int k = 0; k < 5; k++) checkOutput("cont_data", accQ[a0+k], frameExp[fe0+k]);
    for (int k = 1; k < 5; k++) checkOutput("cont_cs_gap", csFallQ[cf0+k] - csRiseQ[cr0+k-1], D * CI);
    checkOutput("cont_overrun", Overrun, 0);

    // Backpressure: second frame is dropped, first held, third delivered.
    a0 = accQ.size(); fe0 = frameExp.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * PERIOD && !Data_Valid; i++) @(negedge clk);
    cycV = cyc;
    held = SPI_Data_out;
    checkOutput("bp_first", held, frameExp[fe0]);
    for (int i = 0; i < 2 * PERIOD && !Overrun; i++) @(negedge clk);
    cycO = cyc;
    checkOutput("bp_overrun", Overrun, 1);
    checkOutput("bp_overrun_time", cycO - cycV, PERIOD);
    checkOutput("bp_held", SPI_Data_out, frameExp[fe0]);
    checkOutput("bp_valid", Data_Valid, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2 * PERIOD && accQ.size() < a0 + 2; i++) @(negedge clk);
    SPI_en = 1'b0;
    checkOutput("bp_accept_held", accQ[a0], frameExp[fe0]);
    checkOutput("bp_third", accQ[a0+1], frameExp[fe0+2]);
    for (int i = 0; i < 2 * PERIOD && Busy; i++) @(negedge clk);
    checkOutput("bp_sticky", Overrun, 1);
    reset_b = 1'b1;
    @(negedge clk);
    checkOutput("ovr_reset_clear", Overrun, 0);
    reset_b = 1'b0;
    @(negedge clk);

    // SPI_en dropped 40 cycles into a continuous frame.
    a0 = accQ.size(); fe0 = frameExp.size(); c0 = csFalls;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && CS; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    SPI_en = 1'b0;
    for (int i = 0; i < 2 * PERIOD && Busy; i++) @(negedge clk);
    checkOutput("drop_idle", Busy, 0);
    repeat (PERIOD) @(negedge clk);
    checkOutput("drop_frames", accQ.size() - a0, 1);
    checkOutput("drop_data", accQ[a0], frameExp[fe0]);
    checkOutput("drop_cs_asserts", csFalls - c0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (PERIOD) @(negedge clk);
    checkOutput("noen_busy", Busy, 0);
    checkOutput("noen_cs_asserts", csFalls - c0, 1);
    checkOutput("noen_frames", accQ.size() - a0, 1);

    // Reset in the middle of SHIFT.
    a0 = accQ.size(); s0 = sclkRise;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < PERIOD && sclkRise - s0 < 7; i++) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cs", CS, 1);
    checkOutput("midrst_sclk", SPI_clk, 1);
    checkOutput("midrst_valid", Data_Valid, 0);
    checkOutput("midrst_busy", Busy, 0);
    reset_b = 1'b0;
    repeat (2 * PERIOD) @(negedge clk);
    checkOutput("midrst_no_stale", accQ.size() - a0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2 * PERIOD && accQ.size() < a0 + 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("midrst_next_count", accQ.size() - a0, 1);
    checkOutput("midrst_next_data", accQ[$], frameExp[$]);
    SPI_en = 1'b0;

    // Second configuration: divide-by-one, 12-bit data, 4 lead bits, 2 channels.
    @(posedge clk);
    #2;
    en2 = 1'b1; cont2 = 1'b1; ready2 = 1'b1;
    for (int i = 0; i < 5 * PERIOD2 && acc2Q.size() < 3; i++) @(negedge clk);
    en2 = 1'b0;
    for (int i = 0; i < 3 * PERIOD2 && busy2; i++) @(negedge clk);
    checkOutput("w12_idle", busy2, 0);
    checkOutput("w12_count_min", acc2Q.size() >= 3, 1);
    checkOutput("w12_spacing1", acc2CycQ[1] - acc2CycQ[0], PERIOD2);
    checkOutput("w12_spacing2", acc2CycQ[2] - acc2CycQ[1], PERIOD2);
    for (int k = 0; k < 3; k++) checkOutput("w12_data", acc2Q[k], exp2Q[k]);
    checkOutput("w12_overrun", overrun2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic f0_set();
    cf0 = csFallQ.size();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
